vdc_vram_arbiter: RTL and testbench
===================================

Name: vdc_vram_arbiter

Overview:
Single-port VRAM arbiter for the HuC6270 VDC. It shares one 16-bit VRAM bus among four requesters: background tile fetch (BG), sprite pattern/SATB fetch (SPR), CPU port accesses (CPU) and VRAM-to-VRAM DMA (DMA). It issues at most one VRAM command per cycle. It tags reads so each read's data returns to the requester that issued it. It sits between the VDC fetch/CPU/DMA logic and the MA/MRD_n/MWR_n VRAM interface.

Parameters:
AW, 16, VRAM word-address width
DW, 16, VRAM data width
RD_LAT, 2, cycles from a read command cycle until mem_rdata is valid (range 1-4)
STARVE_MAX, 8, number of consecutive CPU wait cycles after which the CPU is promoted

Ports:
clock  in  1  system clock
reset_N  in  1  asynchronous active-low reset
display_active  in  1  1 = active display line; 0 = blanking
bg_req  in  1  BG read request
bg_addr  in  AW  BG read address
bg_gnt  out  1  BG grant
bg_rvalid  out  1  rdata belongs to BG
spr_req  in  1  SPR read request
spr_addr  in  AW  SPR read address
spr_gnt  out  1  SPR grant
spr_rvalid  out  1  rdata belongs to SPR
cpu_req  in  1  CPU request
cpu_we  in  1  CPU write (1) or read (0)
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU grant
cpu_rvalid  out  1  rdata belongs to CPU
dma_req  in  1  DMA request
dma_we  in  1  DMA write (1) or read (0)
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA grant
dma_rvalid  out  1  rdata belongs to DMA
rdata  out  DW  shared read-return data
busy_n  out  1  0 while a CPU request is pending and not granted
mem_addr  out  AW  VRAM address (registered)
mem_wdata  out  DW  VRAM write data (registered)
mem_rd_n  out  1  VRAM read strobe, active-low (registered)
mem_wr_n  out  1  VRAM write strobe, active-low (registered)
mem_rdata  in  DW  VRAM read data

Behaviour:
- Requesters hold req/addr/we/wdata stable until their gnt is seen at a clock edge.
- gnt_* is combinational. At most one gnt is high per cycle, and gnt is only asserted when the matching req is high.
- A grant in cycle t produces the registered VRAM command in cycle t+1: mem_addr, plus mem_rd_n=0 for a read or mem_wr_n=0 with mem_wdata for a write.
- Idle cycle: mem_rd_n=mem_wr_n=1; mem_addr and mem_wdata hold their previous values.
- Priority when display_active=1: BG > SPR > CPU/DMA pair. If cpu_wait == STARVE_MAX, the CPU is promoted to just above SPR (still below BG).
- Priority when display_active=0: CPU/DMA pair > SPR > BG.
- display_active is used combinationally, so a change affects the same cycle's grant.
- CPU/DMA pair: round-robin pointer, reset value = CPU. The pointer moves to the other member after either member is granted. If only one member requests, it wins regardless of the pointer.
- cpu_wait counter:
  - increments each cycle cpu_req=1 and cpu_gnt=0;
  - saturates at STARVE_MAX;
  - clears when cpu_gnt=1 or cpu_req=0.
- Read return:
  - an RD_LAT+1 deep tag pipeline carries {valid, id[1:0]} per command;
  - mem_rdata valid in cycle c+RD_LAT (c = command cycle) is registered into rdata;
  - the matching *_rvalid is pulsed for one cycle at c+RD_LAT+1, i.e. gnt-to-rvalid = RD_LAT+2 cycles (4 at default);
  - writes push valid=0; no rvalid is produced for a write.
- Back-to-back grants every cycle are legal. Rvalids then return in grant order, one per cycle.
- busy_n = ~(cpu_req & ~cpu_gnt), combinational.
- Reset (asserted at any time, async):
  - mem_rd_n=mem_wr_n=1; mem_addr=0, mem_wdata=0, rdata=0;
  - all *_rvalid=0; tag pipeline cleared, so in-flight reads are dropped and never return;
  - RR pointer=CPU; cpu_wait=0.
  - gnt/busy_n follow their combinational equations but no command issues until reset_N=1.

Test Plan:
- Reset then idle: all req=0 → mem_rd_n=mem_wr_n=1, all rvalid=0, busy_n=1, mem_addr=0.
- display_active=1; bg_req and cpu_req both held with bg_addr=0x0100, cpu_addr=0x2000; BG releases after 3 grants → BG granted 3 cycles (mem_addr=0x0100 each); CPU granted in the 4th cycle; cpu_rvalid 4 cycles later with rdata = memory model word at 0x2000.
- display_active=1; bg_req held continuously; spr_req held continuously; cpu_req raised → busy_n=0 and CPU never granted while bg_req=1. With bg_req=0 and spr_req held, CPU is granted after exactly STARVE_MAX=8 wait cycles, then cpu_wait reads 0.
- display_active=0; cpu_req and dma_req held together, both reads → grants alternate CPU, DMA, CPU, DMA. cpu_rvalid/dma_rvalid alternate each cycle with the correct data per address.
- DMA write dma_addr=0x1234, dma_wdata=0xBEEF → mem_wr_n=0, mem_addr=0x1234, mem_wdata=0xBEEF one cycle after dma_gnt; no dma_rvalid. A following CPU read of 0x1234 returns 0xBEEF.
- SPR read granted, then reset_N pulsed low 1 cycle later → spr_rvalid never asserts; all outputs take reset values immediately; RR pointer = CPU after release.

Source files
------------

// File: rtl/vdc_vram_arbiter.sv
// HuC6270 VDC VRAM arbiter: shares one 16-bit VRAM port among BG, SPR, CPU and DMA
// requesters, registers the VRAM command and steers tagged read data back to its owner.
//
// CPU/DMA round-robin pointer:
//   state  | meaning
//   RR_CPU | CPU wins when CPU and DMA both request
//   RR_DMA | DMA wins when CPU and DMA both request
module vdc_vram_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic          clock,
   input  logic          reset_N,
   input  logic          display_active,
   input  logic          bg_req,
   input  logic [AW-1:0] bg_addr,
   output logic          bg_gnt,
   output logic          bg_rvalid,
   input  logic          spr_req,
   input  logic [AW-1:0] spr_addr,
   output logic          spr_gnt,
   output logic          spr_rvalid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] rdata,
   output logic          busy_n,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd_n,
   output logic          mem_wr_n,
   input  logic [DW-1:0] mem_rdata
);

   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam logic [1:0] ID_BG  = 2'd0;
   localparam logic [1:0] ID_SPR = 2'd1;
   localparam logic [1:0] ID_CPU = 2'd2;
   localparam logic [1:0] ID_DMA = 2'd3;

   typedef enum logic {RR_CPU = 1'b0, RR_DMA = 1'b1} rr_e;

   rr_e                   rr_q, rr_d;
   logic [WW-1:0]         cpu_wait_q, cpu_wait_d;
   logic [AW-1:0]         mem_addr_q, mem_addr_d;
   logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
   logic                  mem_rd_n_q, mem_rd_n_d;
   logic                  mem_wr_n_q, mem_wr_n_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [3:0]            rvalid_q, rvalid_d;
   logic [RD_LAT:0]       tag_vld_q, tag_vld_d;
   logic [RD_LAT:0][1:0]  tag_id_q, tag_id_d;

   logic [3:0]            gnt;
   logic                  starved, pair_cpu, pair_dma;
   logic                  cmd_vld, cmd_we;
   logic [1:0]            cmd_id;
   logic [AW-1:0]         cmd_addr;
   logic [DW-1:0]         cmd_wdata;

   always_comb begin
      gnt      = 4'b0000;
      starved  = (cpu_wait_q == WW'(STARVE_MAX));
      pair_cpu = cpu_req & (~dma_req | (rr_q == RR_CPU));
      pair_dma = dma_req & ~pair_cpu;
      if (display_active) begin
         // A starved CPU jumps ahead of sprites but never ahead of BG tile fetch.
         if (bg_req)                 gnt[ID_BG]  = 1'b1;
         else if (cpu_req & starved) gnt[ID_CPU] = 1'b1;
         else if (spr_req)           gnt[ID_SPR] = 1'b1;
         else if (pair_cpu)          gnt[ID_CPU] = 1'b1;
         else if (pair_dma)          gnt[ID_DMA] = 1'b1;
      end else begin
         if (pair_cpu)               gnt[ID_CPU] = 1'b1;
         else if (pair_dma)          gnt[ID_DMA] = 1'b1;
         else if (spr_req)           gnt[ID_SPR] = 1'b1;
         else if (bg_req)            gnt[ID_BG]  = 1'b1;
      end
   end

   always_comb begin
      cmd_vld   = |gnt;
      cmd_we    = 1'b0;
      cmd_id    = ID_BG;
      cmd_addr  = bg_addr;
      cmd_wdata = cpu_wdata;
      if (gnt[ID_SPR]) begin
         cmd_id   = ID_SPR;
         cmd_addr = spr_addr;
      end else if (gnt[ID_CPU]) begin
         cmd_id    = ID_CPU;
         cmd_addr  = cpu_addr;
         cmd_we    = cpu_we;
         cmd_wdata = cpu_wdata;
      end else if (gnt[ID_DMA]) begin
         cmd_id    = ID_DMA;
         cmd_addr  = dma_addr;
         cmd_we    = dma_we;
         cmd_wdata = dma_wdata;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt[ID_CPU])      rr_d = RR_DMA;
      else if (gnt[ID_DMA]) rr_d = RR_CPU;

      cpu_wait_d = '0;
      if (cpu_req & ~gnt[ID_CPU])
         cpu_wait_d = starved ? cpu_wait_q : cpu_wait_q + WW'(1);

      mem_addr_d  = cmd_vld ? cmd_addr : mem_addr_q;
      mem_wdata_d = (cmd_vld & cmd_we) ? cmd_wdata : mem_wdata_q;
      mem_rd_n_d  = ~(cmd_vld & ~cmd_we);
      mem_wr_n_d  = ~(cmd_vld & cmd_we);

      // Index 0 tracks the command on the bus; index RD_LAT lines up with valid mem_rdata.
      tag_vld_d = {tag_vld_q[RD_LAT-1:0], cmd_vld & ~cmd_we};
      tag_id_d  = {tag_id_q[RD_LAT-1:0], cmd_id};
      rvalid_d  = tag_vld_q[RD_LAT] ? (4'b0001 << tag_id_q[RD_LAT]) : 4'b0000;
      rdata_d   = tag_vld_q[RD_LAT] ? mem_rdata : rdata_q;
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         rr_q        <= RR_CPU;
         cpu_wait_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_n_q  <= 1'b1;
         mem_wr_n_q  <= 1'b1;
         rdata_q     <= '0;
         rvalid_q    <= '0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
      end else begin
         rr_q        <= rr_d;
         cpu_wait_q  <= cpu_wait_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_n_q  <= mem_rd_n_d;
         mem_wr_n_q  <= mem_wr_n_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
      end
   end

   assign bg_gnt     = gnt[ID_BG];
   assign spr_gnt    = gnt[ID_SPR];
   assign cpu_gnt    = gnt[ID_CPU];
   assign dma_gnt    = gnt[ID_DMA];
   assign bg_rvalid  = rvalid_q[ID_BG];
   assign spr_rvalid = rvalid_q[ID_SPR];
   assign cpu_rvalid = rvalid_q[ID_CPU];
   assign dma_rvalid = rvalid_q[ID_DMA];
   assign rdata      = rdata_q;
   assign busy_n     = ~(cpu_req & ~gnt[ID_CPU]);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_rd_n   = mem_rd_n_q;
   assign mem_wr_n   = mem_wr_n_q;

endmodule

// File: tb/tb_vdc_vram_arbiter.sv
// Scoreboard bench for vdc_vram_arbiter: directed requests push expected VRAM commands and
// read returns into queues; negedge monitors pop and compare them against the bus and rvalids.
module tb_vdc_vram_arbiter;

   localparam int AW         = 16;
   localparam int DW         = 16;
   localparam int RD_LAT     = 2;
   localparam int STARVE_MAX = 8;

   logic          clock = 1'b0;
   logic          reset_N = 1'b0;
   logic          display_active = 1'b0;
   logic          bg_req = 1'b0, spr_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
   logic [AW-1:0] bg_addr = '0, spr_addr = '0, cpu_addr = '0, dma_addr = '0;
   logic          cpu_we = 1'b0, dma_we = 1'b0;
   logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
   logic          bg_gnt, spr_gnt, cpu_gnt, dma_gnt;
   logic          bg_rvalid, spr_rvalid, cpu_rvalid, dma_rvalid;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic          busy_n, mem_rd_n, mem_wr_n;

   always #5 clock = ~clock;

   vdc_vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clock(clock), .reset_N(reset_N), .display_active(display_active),
      .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid),
      .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .busy_n(busy_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_rdata(mem_rdata)
   );

   typedef struct {logic [1:0] id; logic [15:0] data; int cyc;} rd_t;
   typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata;} cmd_t;

   rd_t  rd_q[$];
   cmd_t cmd_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [15:0] iw(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // VRAM model: returns data in cycle c+RD_LAT for a read command in cycle c
   logic [15:0] mem [logic [15:0]];
   logic [15:0] s0 = '0, s1 = '0, s2 = '0;
   assign mem_rdata = s2;

   function automatic logic [15:0] rd_word(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 16'h5A5A;
   endfunction

   always @(negedge clock) begin
      if (!mem_wr_n) mem[mem_addr] = mem_wdata;
      s2 <= s1;
      s1 <= s0;
      s0 <= !mem_rd_n ? rd_word(mem_addr) : 16'h0000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] enc(input logic [3:0] oh);
      case (oh)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Monitors
   logic [3:0] mon_rv;
   rd_t        mon_rd;
   cmd_t       mon_cmd;

   always @(negedge clock) begin
      if (reset_N) begin
         mon_rv = {dma_rvalid, cpu_rvalid, spr_rvalid, bg_rvalid};
         if (rd_q.size() > 0 && (mon_rv != 4'h0 || rd_q[0].cyc <= cyc)) begin
            mon_rd = rd_q.pop_front();
            chk("rvalid_owner", 32'(mon_rv), 32'(4'b0001 << mon_rd.id));
            chk("rdata", 32'(rdata), 32'(mon_rd.data));
            chk("rvalid_cycle", cyc, mon_rd.cyc);
         end else if (mon_rv != 4'h0) begin
            chk("rvalid_unexpected", 32'(mon_rv), 32'h0);
         end
         if (!mem_rd_n || !mem_wr_n) begin
            if (cmd_q.size() == 0) begin
               chk("cmd_unexpected", 32'({mem_rd_n, mem_wr_n}), 32'h3);
            end else begin
               mon_cmd = cmd_q.pop_front();
               chk("cmd_rd_n", 32'(mem_rd_n), 32'(mon_cmd.we));
               chk("cmd_wr_n", 32'(mem_wr_n), 32'(!mon_cmd.we));
               chk("cmd_addr", 32'(mem_addr), 32'(mon_cmd.addr));
               if (mon_cmd.we) chk("cmd_wdata", 32'(mem_wdata), 32'(mon_cmd.wdata));
            end
         end
      end
   end

   // One cycle: check grants/busy_n, push expected command and read return.
   task automatic step(input string name, input logic [3:0] eg, input logic eb, input logic ewe,
                       input logic [15:0] ea, input logic [15:0] ewd, input logic [15:0] ed);
      rd_t  r;
      cmd_t c;
      @(negedge clock);
      chk({name, "_gnt"}, 32'({dma_gnt, cpu_gnt, spr_gnt, bg_gnt}), 32'(eg));
      chk({name, "_busy_n"}, 32'(busy_n), 32'(eb));
      if (eg != 4'h0) begin
         c.we = ewe; c.addr = ea; c.wdata = ewd;
         cmd_q.push_back(c);
         if (!ewe) begin
            r.id = enc(eg); r.data = ed; r.cyc = cyc + RD_LAT + 2;
            rd_q.push_back(r);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step("idle", 4'h0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_rd_n"}, 32'(mem_rd_n), 32'h1);
      chk({name, "_wr_n"}, 32'(mem_wr_n), 32'h1);
      chk({name, "_addr"}, 32'(mem_addr), 32'h0);
      chk({name, "_wdata"}, 32'(mem_wdata), 32'h0);
      chk({name, "_rdata"}, 32'(rdata), 32'h0);
      chk({name, "_rvalid"}, 32'({dma_rvalid, cpu_rvalid, spr_rvalid, bg_rvalid}), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_reset_outputs("reset");
      chk("reset_busy_n", 32'(busy_n), 32'h1);
      @(posedge clock); #1;
      reset_N = 1'b1;
      idle(2);

      // Active display: BG beats CPU until BG releases
      display_active = 1'b1;
      bg_req = 1'b1; bg_addr = 16'h0100;
      cpu_req = 1'b1; cpu_addr = 16'h2000; cpu_we = 1'b0;
      for (int i = 0; i < 3; i++) step("bg_over_cpu", 4'b0001, 1'b0, 1'b0, 16'h0100, 16'h0, iw(16'h0100));
      bg_req = 1'b0;
      step("cpu_after_bg", 4'b0100, 1'b1, 1'b0, 16'h2000, 16'h0, iw(16'h2000));
      cpu_req = 1'b0;
      idle(6);

      // BG blocks a starved CPU; then CPU promoted over SPR after STARVE_MAX waits
      bg_req = 1'b1; spr_req = 1'b1; spr_addr = 16'h3000;
      cpu_req = 1'b1; cpu_addr = 16'h2002;
      for (int i = 0; i < 12; i++) step("bg_blocks_cpu", 4'b0001, 1'b0, 1'b0, 16'h0100, 16'h0, iw(16'h0100));
      bg_req = 1'b0; cpu_req = 1'b0;
      step("spr_alone", 4'b0010, 1'b1, 1'b0, 16'h3000, 16'h0, iw(16'h3000));
      cpu_req = 1'b1;
      for (int i = 0; i < STARVE_MAX; i++) step("spr_starving_cpu", 4'b0010, 1'b0, 1'b0, 16'h3000, 16'h0, iw(16'h3000));
      step("cpu_promoted", 4'b0100, 1'b1, 1'b0, 16'h2002, 16'h0, iw(16'h2002));
      step("wait_cleared", 4'b0010, 1'b0, 1'b0, 16'h3000, 16'h0, iw(16'h3000));
      cpu_req = 1'b0; spr_req = 1'b0;
      idle(6);

      // Blanking: lone DMA wins, then CPU/DMA alternate ahead of BG
      display_active = 1'b0;
      dma_req = 1'b1; dma_addr = 16'h5000; dma_we = 1'b0;
      step("dma_alone", 4'b1000, 1'b1, 1'b0, 16'h5000, 16'h0, iw(16'h5000));
      dma_addr = 16'h5001;
      cpu_req = 1'b1; cpu_addr = 16'h4000;
      bg_req = 1'b1; bg_addr = 16'h0100;
      step("rr_cpu0", 4'b0100, 1'b1, 1'b0, 16'h4000, 16'h0, iw(16'h4000));
      cpu_addr = 16'h4001;
      step("rr_dma0", 4'b1000, 1'b0, 1'b0, 16'h5001, 16'h0, iw(16'h5001));
      dma_addr = 16'h5002;
      step("rr_cpu1", 4'b0100, 1'b1, 1'b0, 16'h4001, 16'h0, iw(16'h4001));
      cpu_req = 1'b0;
      step("rr_dma1", 4'b1000, 1'b1, 1'b0, 16'h5002, 16'h0, iw(16'h5002));
      dma_req = 1'b0;
      step("bg_last_blank", 4'b0001, 1'b1, 1'b0, 16'h0100, 16'h0, iw(16'h0100));
      bg_req = 1'b0;
      idle(6);

      // DMA write then CPU read-back
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1234; dma_wdata = 16'hBEEF;
      step("dma_write", 4'b1000, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0);
      dma_req = 1'b0; dma_we = 1'b0;
      cpu_req = 1'b1; cpu_addr = 16'h1234;
      step("cpu_readback", 4'b0100, 1'b1, 1'b0, 16'h1234, 16'h0, 16'hBEEF);
      cpu_req = 1'b0;
      idle(6);

      // Reset while an SPR read is in flight
      display_active = 1'b1;
      spr_req = 1'b1; spr_addr = 16'h3000;
      step("spr_inflight", 4'b0010, 1'b1, 1'b0, 16'h3000, 16'h0, iw(16'h3000));
      spr_req = 1'b0;
      @(negedge clock);
      @(posedge clock); #1;
      reset_N = 1'b0;
      rd_q.delete();
      #1;
      chk_reset_outputs("async_reset");
      @(posedge clock); #1;
      reset_N = 1'b1;
      idle(6);

      // Pointer back at CPU after reset
      display_active = 1'b0;
      cpu_req = 1'b1; cpu_addr = 16'h4100;
      dma_req = 1'b1; dma_addr = 16'h5100;
      step("rr_after_reset", 4'b0100, 1'b1, 1'b0, 16'h4100, 16'h0, iw(16'h4100));
      cpu_req = 1'b0;
      step("dma_after_reset", 4'b1000, 1'b1, 1'b0, 16'h5100, 16'h0, iw(16'h5100));
      dma_req = 1'b0;
      idle(6);

      chk("rd_queue_drained", rd_q.size(), 0);
      chk("cmd_queue_drained", cmd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
